// File: rtl/logic_unit.sv
// logic_unit: registered bitwise operation unit with a valid/ready handshake.
// Each beat computes r = a op b. An optional accumulate mode folds a stream
// of beats into one result with AND, OR or XOR. Result flags are registered
// together with the result.
module logic_unit #(
  parameter int DW      = 32,
  parameter int ACC_MAX = 16,
  parameter int CW      = $clog2(ACC_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  input  logic          acc_en,
  input  logic [1:0]    acc_op,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_zero,
  output logic          out_ones,
  output logic [CW-1:0] out_beats,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ACC_MAX_C = CW'(ACC_MAX);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_t        state_reg, state_next;
  logic [DW-1:0] acc_reg, acc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    acc_op_reg, acc_op_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic          out_zero_reg, out_zero_next;
  logic          out_ones_reg, out_ones_next;
  logic [CW-1:0] out_beats_reg, out_beats_next;
  logic          ovf_reg, ovf_next;

  logic [3:0]    op_tt;
  logic [DW-1:0] beat_r;
  logic [DW-1:0] folded;
  logic [CW-1:0] count_plus;
  logic          accept;

  // Truth table for the selected op, indexed by {a_bit, b_bit}.
  always_comb begin
    case (op)
      3'd0:    op_tt = 4'b1000;  // AND
      3'd1:    op_tt = 4'b1110;  // OR
      3'd2:    op_tt = 4'b0110;  // XOR
      3'd3:    op_tt = 4'b0111;  // NAND
      3'd4:    op_tt = 4'b0001;  // NOR
      3'd5:    op_tt = 4'b1001;  // XNOR
      3'd6:    op_tt = 4'b1100;  // PASS_A
      default: op_tt = 4'b0011;  // NOT_A
    endcase
  end

  // Each result bit is a lookup of its own operand bit pair.
  for (genvar gi = 0; gi < DW; gi++) begin : g_bit
    assign beat_r[gi] = op_tt[{a[gi], b[gi]}];
  end

  // Fold the current beat into the accumulator with the sampled combiner.
  always_comb begin
    case (acc_op_reg)
      2'd0:    folded = acc_reg & beat_r;
      2'd1:    folded = acc_reg | beat_r;
      default: folded = acc_reg ^ beat_r;
    endcase
  end

  assign count_plus = count_reg + ONE_C;
  assign in_ready   = (state_reg != OUT) || out_ready;
  assign accept     = in_valid && in_ready;

  // Next-state and next-result logic; every register holds by default.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    acc_op_next    = acc_op_reg;
    out_data_next  = out_data_reg;
    out_zero_next  = out_zero_reg;
    out_ones_next  = out_ones_reg;
    out_beats_next = out_beats_reg;
    ovf_next       = ovf_reg;
    case (state_reg)
      IDLE, OUT: begin
        if (accept) begin
          // First beat: in OUT this also consumes the pending result.
          if (!acc_en || in_last) begin
            out_data_next  = beat_r;
            out_zero_next  = ~|beat_r;
            out_ones_next  = &beat_r;
            out_beats_next = ONE_C;
            ovf_next       = 1'b0;
            state_next     = OUT;
          end else begin
            acc_next    = beat_r;
            count_next  = ONE_C;
            acc_op_next = acc_op;
            state_next  = ACC;
          end
        end else if (state_reg == OUT && out_ready) begin
          state_next = IDLE;
        end
      end
      ACC: begin
        // in_ready is always 1 here, so in_valid alone accepts a beat.
        if (in_valid) begin
          count_next = count_plus;
          if (in_last || count_plus == ACC_MAX_C) begin
            out_data_next  = folded;
            out_zero_next  = ~|folded;
            out_ones_next  = &folded;
            out_beats_next = count_plus;
            ovf_next       = !in_last;
            acc_next       = '0;
            state_next     = OUT;
          end else begin
            acc_next = folded;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      acc_op_reg    <= '0;
      out_data_reg  <= '0;
      out_zero_reg  <= 1'b0;
      out_ones_reg  <= 1'b0;
      out_beats_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      acc_op_reg    <= acc_op_next;
      out_data_reg  <= out_data_next;
      out_zero_reg  <= out_zero_next;
      out_ones_reg  <= out_ones_next;
      out_beats_reg <= out_beats_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign out_valid = (state_reg == OUT);
  assign out_data  = out_data_reg;
  assign out_zero  = out_zero_reg;
  assign out_ones  = out_ones_reg;
  assign out_beats = out_beats_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: directed tests of logic_unit with DW=8, ACC_MAX=4.
module tb_logic_unit;

  localparam int DW = 8;
  localparam int ACC_MAX = 4;
  localparam int CW = $clog2(ACC_MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [2:0]    op = '0;
  logic          acc_en = 1'b0;
  logic [1:0]    acc_op = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_zero;
  logic          out_ones;
  logic [CW-1:0] out_beats;
  logic          ovf;

  int total = 0;
  int bad = 0;

  logic_unit #(.DW(DW), .ACC_MAX(ACC_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_op(acc_op),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
    .out_beats(out_beats), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    total++; if (out_zero !== 1'b0 || out_ones !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", out_zero, out_ones); end
    total++; if (out_beats !== 3'd0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_beats_ovf got=%0d/%b want=0/0", out_beats, ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    $display("reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
  endtask

  task automatic test_single_ops;
    logic [7:0] exp_ops [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
    out_ready = 1'b1;
    acc_en = 1'b0;
    in_last = 1'b0;
    a = 8'hF0;
    b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      op = 3'(i);
      step();
      total++; if (out_valid !== 1'b1 || out_data !== exp_ops[i]) begin bad++; $display("FAIL single_op%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp_ops[i]); end
      total++; if (out_beats !== 3'd1 || ovf !== 1'b0) begin bad++; $display("FAIL single_op%0d_beats got=%0d/%b want=1/0", i, out_beats, ovf); end
      $display("single op=%0d a=%h b=%h -> out_data=%h", i, a, b, out_data);
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h0F) begin bad++; $display("FAIL single_drain got=%b/%h want=0/0f", out_valid, out_data); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    acc_en = 1'b0;
    op = 3'd6;
    b = 8'h00;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 8'h10 + 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL b2b_data%0d got=%b/%h want=1/%h", i, out_valid, out_data, 8'h10 + 8'(i)); end
      $display("b2b beat %0d a=%h -> out_data=%h", i, a, out_data);
    end
    out_ready = 1'b0;
    a = 8'h77;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", in_ready); end
    step();
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h19) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/19", out_valid, out_data); end
    $display("stall: in_ready=%b out_data=%h", in_ready, out_data);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", out_valid); end
  endtask

  task automatic test_acc_xor;
    logic [7:0] beats_a [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    out_ready = 1'b1;
    acc_en = 1'b1;
    acc_op = 2'd2;
    op = 3'd6;
    b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = beats_a[i];
      in_last = (i == 3);
      step();
      if (i < 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL accx_busy%0d got=%b want=0", i, out_valid); end
      end
      if (i == 1) begin
        // Idle cycle inside the accumulation must hold state.
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL accx_hold got=%b want=0", out_valid); end
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin bad++; $display("FAIL accx_data got=%b/%h want=1/0f", out_valid, out_data); end
    total++; if (out_beats !== 3'd4 || ovf !== 1'b0) begin bad++; $display("FAIL accx_beats got=%0d/%b want=4/0", out_beats, ovf); end
    $display("acc xor: out_data=%h beats=%0d ovf=%b", out_data, out_beats, ovf);
    step();
    // AND accumulation: (FF&0F)=0F, (F3&FF)=F3, 0F&F3=03.
    acc_op = 2'd0;
    op = 3'd0;
    in_valid = 1'b1;
    a = 8'hFF; b = 8'h0F; in_last = 1'b0;
    step();
    a = 8'hF3; b = 8'hFF; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin bad++; $display("FAIL acca_data got=%b/%h want=1/03", out_valid, out_data); end
    total++; if (out_zero !== 1'b0 || out_ones !== 1'b0 || out_beats !== 3'd2) begin bad++; $display("FAIL acca_flags got=%b%b/%0d want=00/2", out_zero, out_ones, out_beats); end
    $display("acc and: out_data=%h beats=%0d zero=%b", out_data, out_beats, out_zero);
    step();
  endtask

  task automatic test_overflow;
    logic [7:0] beats_a [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    out_ready = 1'b1;
    acc_en = 1'b1;
    acc_op = 2'd1;
    op = 3'd6;
    b = 8'h00;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = beats_a[i];
      step();
      if (i == 3) begin
        total++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin bad++; $display("FAIL ovf_data got=%b/%h want=1/0f", out_valid, out_data); end
        total++; if (ovf !== 1'b1 || out_beats !== 3'd4) begin bad++; $display("FAIL ovf_flag got=%b/%0d want=1/4", ovf, out_beats); end
        $display("overflow: out_data=%h beats=%0d ovf=%b", out_data, out_beats, ovf);
      end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_restart got=%b want=0", out_valid); end
    a = 8'h20;
    in_last = 1'b1;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    total++; if (out_data !== 8'h30 || out_beats !== 3'd2 || ovf !== 1'b0) begin bad++; $display("FAIL ovf_next got=%h/%0d/%b want=30/2/0", out_data, out_beats, ovf); end
    $display("after overflow: out_data=%h beats=%0d ovf=%b", out_data, out_beats, ovf);
    step();
  endtask

  task automatic test_flags;
    out_ready = 1'b1;
    acc_en = 1'b0;
    in_valid = 1'b1;
    a = 8'h55; b = 8'hAA; op = 3'd2;
    step();
    total++; if (out_data !== 8'hFF || out_ones !== 1'b1 || out_zero !== 1'b0) begin bad++; $display("FAIL flags_ones got=%h/%b%b want=ff/01", out_data, out_zero, out_ones); end
    $display("flags xor: out_data=%h zero=%b ones=%b", out_data, out_zero, out_ones);
    op = 3'd0;
    step();
    total++; if (out_data !== 8'h00 || out_zero !== 1'b1 || out_ones !== 1'b0) begin bad++; $display("FAIL flags_zero got=%h/%b%b want=00/10", out_data, out_zero, out_ones); end
    $display("flags and: out_data=%h zero=%b ones=%b", out_data, out_zero, out_ones);
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    acc_en = 1'b0;
    in_valid = 1'b1;
    a = 8'hF0; b = 8'hFF; op = 3'd0;
    step();
    // Start an accumulation directly from OUT, then reset after 2 of 3 beats.
    acc_en = 1'b1; acc_op = 2'd1; op = 3'd6; in_last = 1'b0;
    a = 8'h01;
    step();
    a = 8'h02;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 8'hF0) begin bad++; $display("FAIL mid_keep got=%b/%h want=0/f0", out_valid, out_data); end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_beats !== 3'd0) begin bad++; $display("FAIL mid_reset got=%b/%h/%0d want=0/00/0", out_valid, out_data, out_beats); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", in_ready); end
    $display("reset mid-acc: out_valid=%b out_data=%h", out_valid, out_data);
    acc_en = 1'b0; op = 3'd0; a = 8'h0F; b = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F || out_beats !== 3'd1) begin bad++; $display("FAIL mid_after got=%b/%h/%0d want=1/0f/1", out_valid, out_data, out_beats); end
    $display("after reset single and: out_data=%h beats=%0d", out_data, out_beats);
    step();
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_acc_xor();
    test_overflow();
    test_flags();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
Name: logic_unit

Overview:
- Parametrised, registered successor to the team's two-input combinational gate.
- Applies one of eight bitwise operations to two DW-bit operands under a valid/ready handshake.
- Optional accumulate mode folds a multi-beat operand stream into one result using AND, OR or XOR.
- Used in the P03 datapath wherever a multi-bit or streamed logic reduction is needed, with status flags for the control FSM.

Parameters:
- DW, 32, operand and result width in bits.
- ACC_MAX, 16, maximum beats in one accumulation; must be >= 2.
- CW, $clog2(ACC_MAX+1), width of the beat counter (derived).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  DW  operand A.
- b  in  DW  operand B.
- op  in  3  per-beat operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A.
- acc_en  in  1  1 = beat starts or continues an accumulation.
- acc_op  in  2  accumulation combiner: 0 AND, 1 OR, 2 XOR; 3 is treated as XOR.
- in_last  in  1  final beat of an accumulation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DW  result.
- out_zero  out  1  out_data is all zeros.
- out_ones  out  1  out_data is all ones.
- out_beats  out  CW  number of beats folded into out_data.
- ovf  out  1  accumulation closed at ACC_MAX beats without in_last.

Behaviour:
- Reset: one clk edge with rst=0 forces state IDLE; out_valid, out_data, out_zero, out_ones, out_beats, ovf all go to 0; the partial accumulator is cleared.
- Reset mid-accumulation or with a result pending discards all data.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - in_ready = (state != OUT) || out_ready, purely combinational; full throughput is allowed.
  - in_ready is 1 out of reset.
- Per-beat result: r = a op b, computed at full DW width.
- FSM states: IDLE, ACC, OUT.
- IDLE or OUT with a beat accepted while out_ready (a first beat):
  - op, acc_en and acc_op are sampled.
  - If acc_en=0 or in_last=1: out_data <= r, out_beats <= 1, ovf <= 0, next state OUT. Latency is 1 cycle.
  - Otherwise: acc <= r, count <= 1, next state ACC.
- ACC with a beat accepted:
  - acc <= acc COMB r, where COMB is the sampled acc_op. Each beat's r uses that beat's own op.
  - acc_en on later beats is ignored.
  - count increments.
  - If in_last=1 or count+1 == ACC_MAX: move the result to out_data with out_beats = count+1, set ovf=1 only when closed by ACC_MAX without in_last, next state OUT.
- ACC while in_valid=0: hold everything; there is no timeout.
- OUT:
  - out_valid=1; out_data and flags are stable until out_ready.
  - out_ready without a new beat: next state IDLE, out_valid <= 0. out_data keeps its last value.
  - out_ready with a new beat in the same cycle: the result is consumed and the beat is treated as a first beat. There are no bubbles.
- out_zero and out_ones are registered in the same cycle as out_data and are never combinational from out_data.
- No arithmetic on data; all operations are strictly bitwise and never change width.
- in_valid, a, b, op and in_last values are don't-care when not accepted.

Test Plan:
- Single ops, DW=8: a=8'hF0, b=8'h3C with op 0..7 -> out_data = 30, FC, CC, CF, 03, 33, F0, 0F on consecutive cycles; out_valid the cycle after each accept; out_beats=1.
- Back-to-back throughput: in_valid=1 and out_ready=1 held for 10 beats -> in_ready stays 1 and 10 results appear in order with no gaps. out_ready held low -> in_ready=0, out_data held.
- Accumulate XOR: acc_op=2, op=PASS_A, a = 01, 02, 04, 08 with in_last on the 4th beat -> out_data=0F, out_beats=4, ovf=0. With op=AND/acc_op=AND, beats (FF,0F) then (F3,FF) -> out_data=03, out_zero=0.
- Overflow: ACC_MAX=4, acc_op=OR, 5 beats with no in_last -> result after beat 4 with ovf=1, out_beats=4; the 5th beat starts a new result.
- Flags: a=55, b=AA with op=XOR -> out_data=FF, out_ones=1. op=AND -> out_data=00, out_zero=1.
- Reset mid-accumulation: rst=0 after 2 of 3 beats -> next cycle out_valid=0, out_data=0, state IDLE; a following single AND produces only the new result with out_beats=1.
